// File: rtl/aplic_prio_scanner.sv
// rtl/aplic_prio_scanner.sv - APLIC priority scanner: multi-cycle sweep of
// interrupt sources, publishing the best eligible source and handling claims.
module aplic_prio_scanner #(
  parameter int NR_SRC = 32,
  parameter int LANES  = 4,
  parameter int PRIO_W = 3
) (
  input  logic                       i_clk,
  input  logic                       ni_rst,
  input  logic [NR_SRC-1:0]          i_pending,
  input  logic [NR_SRC-1:0]          i_enabled,
  input  logic [NR_SRC*PRIO_W-1:0]   i_prio,
  input  logic [PRIO_W-1:0]          i_ithreshold,
  input  logic                       i_idelivery,
  input  logic                       i_claim,
  output logic [$clog2(NR_SRC)-1:0]  o_topi_id,
  output logic [PRIO_W-1:0]          o_topi_prio,
  output logic                       o_eip,
  output logic                       o_clr_valid,
  output logic [$clog2(NR_SRC)-1:0]  o_clr_id
);

  localparam int ID_W   = $clog2(NR_SRC);
  localparam int NR_GRP = NR_SRC / LANES;
  localparam int GRP_W  = (NR_GRP > 1) ? $clog2(NR_GRP) : 1;
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NR_GRP - 1);

  typedef enum logic [1:0] {SCAN, PUBLISH, CLAIM} state_t;

  state_t            state, state_nxt;
  logic [GRP_W-1:0]  grp;
  logic [ID_W-1:0]   best_id, scan_id;
  logic [PRIO_W-1:0] best_prio, scan_prio;
  logic [PRIO_W-1:0] prio_arr [NR_SRC];

  for (genvar i = 0; i < NR_SRC; i++) begin : g_prio
    assign prio_arr[i] = i_prio[i*PRIO_W +: PRIO_W];
  end

  // Fold the current group into the running best; lanes are visited in
  // ascending id order and only strictly better priorities win, so ties
  // keep the lower id. best_id == 0 stands for "none".
  always_comb begin
    logic [ID_W-1:0]   src;
    logic [PRIO_W-1:0] eff;
    logic              elig;
    scan_id   = best_id;
    scan_prio = best_prio;
    src       = '0;
    eff       = '0;
    elig      = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      src  = ID_W'(int'(grp) * LANES + l);
      eff  = (prio_arr[src] == '0) ? PRIO_W'(1) : prio_arr[src];
      elig = (src != '0) && i_pending[src] && i_enabled[src] &&
             ((i_ithreshold == '0) || (eff < i_ithreshold));
      if (elig && ((scan_id == '0) || (eff < scan_prio))) begin
        scan_id   = src;
        scan_prio = eff;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SCAN: begin
        if (i_claim)              state_nxt = CLAIM;
        else if (grp == LAST_GRP) state_nxt = PUBLISH;
      end
      PUBLISH: state_nxt = i_claim ? CLAIM : SCAN;
      CLAIM:   state_nxt = SCAN;
      default: state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      state       <= SCAN;
      grp         <= '0;
      best_id     <= '0;
      best_prio   <= '0;
      o_topi_id   <= '0;
      o_topi_prio <= '0;
      o_clr_id    <= '0;
    end else begin
      state <= state_nxt;
      if ((state != CLAIM) && i_claim) begin
        // A claim returns the currently published id and drops any publish.
        o_clr_id    <= o_topi_id;
        o_topi_id   <= '0;
        o_topi_prio <= '0;
        best_id     <= '0;
        best_prio   <= '0;
        grp         <= '0;
      end else begin
        case (state)
          SCAN: begin
            best_id   <= scan_id;
            best_prio <= scan_prio;
            grp       <= (grp == LAST_GRP) ? '0 : grp + GRP_W'(1);
          end
          PUBLISH: begin
            o_topi_id   <= best_id;
            o_topi_prio <= best_prio;
            best_id     <= '0;
            best_prio   <= '0;
            grp         <= '0;
          end
          default: begin
            o_topi_id   <= '0;
            o_topi_prio <= '0;
            best_id     <= '0;
            best_prio   <= '0;
            grp         <= '0;
          end
        endcase
      end
    end
  end

  assign o_clr_valid = (state == CLAIM) && (o_clr_id != '0);
  assign o_eip       = i_idelivery && (o_topi_id != '0);

endmodule

// File: tb/tb_aplic_prio_scanner.sv
// tb/tb_aplic_prio_scanner.sv - bench for aplic_prio_scanner: vector table
// with a scoreboard queue plus claim, latency and reset sequences.
module tb_aplic_prio_scanner;

  localparam int NR_SRC = 32;
  localparam int LANES  = 4;
  localparam int PRIO_W = 3;
  localparam int ID_W   = 5;
  localparam int SWEEP  = 9;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NR_SRC-1:0]        pending, enabled;
  logic [NR_SRC*PRIO_W-1:0] prio;
  logic [PRIO_W-1:0]        thr;
  logic                     idel, claim;
  logic [ID_W-1:0]          topi_id, clr_id;
  logic [PRIO_W-1:0]        topi_prio;
  logic                     eip, clr_valid;

  aplic_prio_scanner #(.NR_SRC(NR_SRC), .LANES(LANES), .PRIO_W(PRIO_W)) dut (
    .i_clk(clk), .ni_rst(rst_n), .i_pending(pending), .i_enabled(enabled),
    .i_prio(prio), .i_ithreshold(thr), .i_idelivery(idel), .i_claim(claim),
    .o_topi_id(topi_id), .o_topi_prio(topi_prio), .o_eip(eip),
    .o_clr_valid(clr_valid), .o_clr_id(clr_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR_SRC-1:0]        pend;
    logic [NR_SRC-1:0]        en;
    logic [NR_SRC*PRIO_W-1:0] pr;
    logic [PRIO_W-1:0]        th;
    logic                     dl;
    int                       eid;
    int                       eprio;
    int                       eeip;
  } vec_t;

  typedef struct {
    int eid;
    int eprio;
    int eeip;
  } exp_t;

  vec_t                  vecs[$];
  exp_t                  sb[$];
  logic [NR_SRC*PRIO_W-1:0] cur_pr;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_pr(input int id, input int p);
    cur_pr[id*PRIO_W +: PRIO_W] = PRIO_W'(p);
  endtask

  task automatic add_vec(input logic [NR_SRC-1:0] pd, input logic [NR_SRC-1:0] en,
                         input int th, input logic dl, input int eid, input int ep,
                         input int ee);
    vec_t v;
    v.pend = pd; v.en = en; v.pr = cur_pr; v.th = PRIO_W'(th); v.dl = dl;
    v.eid = eid; v.eprio = ep; v.eeip = ee;
    vecs.push_back(v);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Count rising edges from reset release until a nonzero topi is seen.
  task automatic measure_latency(input string name);
    int cnt = 0;
    bit seen = 0;
    rst_n = 1'b1;
    while (!seen && cnt < 40) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (topi_id != '0) seen = 1;
    end
    if (!seen) chk({name, "_timeout"}, 0, 1);
    else       chk(name, cnt, SWEEP);
  endtask

  initial begin
    rst_n = 1'b0; claim = 1'b0; idel = 1'b1; thr = '0;
    pending = '0; enabled = '0; prio = '1;

    cur_pr = '1;
    add_vec(32'h0, 32'hFFFF_FFFF, 0, 1'b1, 0, 0, 0);
    set_pr(5, 3);
    add_vec(32'h0000_0020, 32'h0000_0020, 0, 1'b1, 5, 3, 1);
    add_vec(32'h0000_0020, 32'h0000_0020, 0, 1'b0, 5, 3, 0);
    cur_pr = '1; set_pr(7, 2); set_pr(20, 2); set_pr(3, 4);
    add_vec(32'h0010_0088, 32'h0010_0088, 0, 1'b1, 7, 2, 1);
    set_pr(20, 1);
    add_vec(32'h0010_0088, 32'h0010_0088, 0, 1'b1, 20, 1, 1);
    cur_pr = '1; set_pr(9, 5);
    add_vec(32'h0000_0200, 32'h0000_0200, 5, 1'b1, 0, 0, 0);
    add_vec(32'h0000_0200, 32'h0000_0200, 6, 1'b1, 9, 5, 1);
    cur_pr = '1; set_pr(0, 1); set_pr(31, 0);
    add_vec(32'h8000_0001, 32'h8000_0001, 0, 1'b1, 31, 1, 1);
    cur_pr = '1;
    add_vec(32'h0000_1000, 32'h0000_0000, 0, 1'b1, 0, 0, 0);
    add_vec(32'h0000_0C00, 32'h0000_0C00, 0, 1'b1, 10, 7, 1);
    add_vec(32'h0000_0C00, 32'h0000_0C00, 1, 1'b1, 0, 0, 0);

    #1;
    chk("reset_topi_id", topi_id, 0);
    chk("reset_topi_prio", topi_prio, 0);
    chk("reset_eip", eip, 0);
    chk("reset_clr_valid", clr_valid, 0);
    chk("reset_clr_id", clr_id, 0);
    cycles(2);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      pending = vecs[i].pend; enabled = vecs[i].en; prio = vecs[i].pr;
      thr = vecs[i].th; idel = vecs[i].dl;
      e.eid = vecs[i].eid; e.eprio = vecs[i].eprio; e.eeip = vecs[i].eeip;
      sb.push_back(e);
      cycles(2 * SWEEP + 2);
      e = sb.pop_front();
      chk($sformatf("vec%0d_topi_id", i), topi_id, e.eid);
      chk($sformatf("vec%0d_topi_prio", i), topi_prio, e.eprio);
      chk($sformatf("vec%0d_eip", i), eip, e.eeip);
      chk($sformatf("vec%0d_clr_valid", i), clr_valid, 0);
    end

    // Exact first-publish latency after reset release.
    prio = '1; prio[5*PRIO_W +: PRIO_W] = 3'd3;
    pending = 32'h0000_0020; enabled = 32'h0000_0020; thr = '0; idel = 1'b1;
    @(negedge clk); rst_n = 1'b0; cycles(2);
    measure_latency("latency_after_reset");
    chk("latency_topi_prio", topi_prio, 3);

    // Claim held two cycles: one strobe only, second cycle ignored.
    claim = 1'b1; pending = '0;
    @(negedge clk);
    chk("claim_clr_valid", clr_valid, 1);
    chk("claim_clr_id", clr_id, 5);
    chk("claim_topi_cleared", topi_id, 0);
    chk("claim_eip_cleared", eip, 0);
    @(negedge clk);
    chk("claim_in_claim_no_strobe", clr_valid, 0);
    claim = 1'b0;
    cycles(2 * SWEEP + 2);
    chk("after_claim_topi_stays_0", topi_id, 0);
    chk("clr_id_holds", clr_id, 5);
    claim = 1'b1;
    @(negedge clk);
    claim = 1'b0;
    chk("empty_claim_clr_valid", clr_valid, 0);
    chk("empty_claim_clr_id", clr_id, 0);

    // Reset in the middle of a sweep (group 4) after a publish.
    pending = 32'h0000_0020;
    @(negedge clk); rst_n = 1'b0; cycles(2);
    measure_latency("latency_pre_midreset");
    cycles(4);
    rst_n = 1'b0;
    #1;
    chk("midreset_topi_id", topi_id, 0);
    chk("midreset_topi_prio", topi_prio, 0);
    chk("midreset_eip", eip, 0);
    chk("midreset_clr_valid", clr_valid, 0);
    chk("midreset_clr_id", clr_id, 0);
    @(negedge clk);
    measure_latency("latency_after_midreset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
